// File: rtl/div_pkg.sv
// Shared definitions for the colour-adjust divider output stage: default widths,
// chain latency derivation, pixel ceiling and the sideband bundle.
package div_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_M     = 8;
    localparam int unsigned DEF_OUT_W = 8;
    localparam int unsigned PIX_MAX   = (1 << DEF_OUT_W) - 1;

    // One divider cell per quotient bit.
    function automatic int unsigned div_lat(input int unsigned n, input int unsigned m);
        return n - m + 1;
    endfunction

    typedef struct packed {
        logic dz;
        logic vs;
        logic hs;
        logic de;
    } sideband_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset; delays a
// Width-bit word by exactly Depth clock cycles.
module sync_delay_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Depth];

    for (genvar g = 0; g < Depth; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) stage_q[0] <= '0;
                else         stage_q[0] <= d_i;
            end
        end else begin : g_rest
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) stage_q[g] <= '0;
                else         stage_q[g] <= stage_q[g-1];
            end
        end
    end

    assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/divider_round_sat.sv
// Divider output stage: round-half-up (DIV_ROUND_EN) or truncate, saturate to OUT_W,
// re-align sideband, per-frame saturation count and sticky misalignment flag.
module divider_round_sat
    import div_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned M     = DEF_M,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned LAT   = div_lat(N, M)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rdy_i,
    input  logic [N-M:0]       quotient_i,
    input  logic [M-1:0]       remainder_i,
    input  logic [M-1:0]       divisor_i,
    input  logic               de_i,
    input  logic               hs_i,
    input  logic               vs_i,
    input  logic               dz_i,
    output logic               de_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic [OUT_W-1:0]   pix_o,
    output logic [15:0]        sat_cnt_o,
    output logic               align_err_o
);

    localparam int unsigned QW = N - M + 1;
    localparam logic [QW:0] PixMaxQ = (QW+1)'((1 << OUT_W) - 1);
    localparam logic [OUT_W-1:0] PixMaxO = '1;

    sideband_t sb_in, sb_dly;

    assign sb_in = '{dz: dz_i, vs: vs_i, hs: hs_i, de: de_i};

    sync_delay_line #(
        .Width ($bits(sideband_t)),
        .Depth (LAT)
    ) u_sb_delay (
        .clk_i  (clk),
        .rst_ni (resetn),
        .d_i    (sb_in),
        .q_o    (sb_dly)
    );

    logic [QW:0] q_r;

`ifdef DIV_ROUND_EN
    logic [M:0] rem2;
    logic       round_up;
    assign rem2     = {remainder_i, 1'b0};
    assign round_up = (rem2 >= {1'b0, divisor_i});
    assign q_r      = {1'b0, quotient_i} + {{QW{1'b0}}, round_up};
`else
    logic unused_round;
    assign unused_round = ^{remainder_i, divisor_i};
    assign q_r          = {1'b0, quotient_i};
`endif

    logic             sat, sat_hit, vs_rise;
    logic [OUT_W-1:0] pix_d, pix_q;
    logic [15:0]      cnt_d, cnt_q, cnt_inc, sat_cnt_d, sat_cnt_q;
    logic             align_err_d, align_err_q;
    logic             de_q, hs_q, vs_q;

    always_comb begin
        sat       = sb_dly.dz | (q_r > PixMaxQ);
        sat_hit   = rdy_i & sat;
        pix_d     = '0;
        if (rdy_i) pix_d = sat ? PixMaxO : q_r[OUT_W-1:0];
        cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + {15'b0, sat_hit};
        // vs_q holds last cycle's delayed vs, so it doubles as the edge detector.
        vs_rise   = sb_dly.vs & ~vs_q;
        sat_cnt_d = sat_cnt_q;
        cnt_d     = cnt_inc;
        if (vs_rise) begin
            sat_cnt_d = cnt_inc;
            cnt_d     = {15'b0, sat_hit};
        end
        align_err_d = align_err_q | (rdy_i ^ sb_dly.de);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            cnt_q       <= '0;
            sat_cnt_q   <= '0;
            align_err_q <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            de_q        <= sb_dly.de;
            hs_q        <= sb_dly.hs;
            vs_q        <= sb_dly.vs;
            cnt_q       <= cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            align_err_q <= align_err_d;
        end
    end

    assign pix_o       = pix_q;
    assign de_o        = de_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign sat_cnt_o   = sat_cnt_q;
    assign align_err_o = align_err_q;

endmodule

// File: tb/tb_divider_round_sat.sv
// Directed bench for divider_round_sat; expected outputs come from a small
// behavioural model queued per cycle and popped after each clock edge.
module tb_divider_round_sat;
    import div_pkg::*;

    localparam int unsigned N     = 16;
    localparam int unsigned M     = 8;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned LAT   = N - M + 1;
`ifdef DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic         clk, resetn, rdy_i, de_i, hs_i, vs_i, dz_i;
    logic [N-M:0] quotient_i;
    logic [M-1:0] remainder_i, divisor_i;
    logic         de_o, hs_o, vs_o, align_err_o;
    logic [7:0]   pix_o;
    logic [15:0]  sat_cnt_o;

    divider_round_sat #(.N(N), .M(M), .OUT_W(OUT_W), .LAT(LAT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rdy_i       (rdy_i),
        .quotient_i  (quotient_i),
        .remainder_i (remainder_i),
        .divisor_i   (divisor_i),
        .de_i        (de_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .dz_i        (dz_i),
        .de_o        (de_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .pix_o       (pix_o),
        .sat_cnt_o   (sat_cnt_o),
        .align_err_o (align_err_o)
    );

    typedef struct packed {
        logic [7:0]  pix;
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] sat_cnt;
        logic        err;
    } exp_t;

    exp_t      sb_q[$];
    sideband_t hist[$];
    int        m_cnt, m_satcnt;
    bit        m_err, m_prev_vs;
    int        n_cmp = 0;
    int        n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input int q, input int rem, input int dv);
        int r;
        r = (2 * rem >= dv) ? 1 : 0;
        return q + RND * r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        {rdy_i, de_i, hs_i, vs_i, dz_i} = '0;
        quotient_i = '0; remainder_i = '0; divisor_i = '0;
        #1;
        check("rst_pix", pix_o, 0);
        check("rst_de", de_o, 0);
        check("rst_hs", hs_o, 0);
        check("rst_vs", vs_o, 0);
        check("rst_satcnt", sat_cnt_o, 0);
        check("rst_alignerr", align_err_o, 0);
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back('0);
        sb_q.delete();
        m_cnt = 0; m_satcnt = 0; m_err = 0; m_prev_vs = 0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One clock: drive at negedge, model the cycle, compare just after posedge.
    task automatic step(input logic de, input logic hs, input logic vs, input logic dz,
                        input int q, input int rem, input int dv, input bit mis);
        sideband_t dly;
        exp_t      e;
        int        qr, inc;
        bit        sat, hit, rdy;
        @(negedge clk);
        dly = hist.pop_front();
        rdy = dly.de ^ mis;
        rdy_i = rdy; de_i = de; hs_i = hs; vs_i = vs; dz_i = dz;
        quotient_i = (N-M+1)'(q); remainder_i = M'(rem); divisor_i = M'(dv);
        hist.push_back('{dz: dz, vs: vs, hs: hs, de: de});
        qr  = rnd(q, rem, dv);
        sat = dly.dz || (qr > 255);
        hit = rdy && sat;
        e.pix = !rdy ? 8'd0 : (sat ? 8'd255 : 8'(qr));
        inc = (m_cnt == 65535) ? m_cnt : m_cnt + int'(hit);
        if (dly.vs && !m_prev_vs) begin
            m_satcnt = inc;
            m_cnt    = int'(hit);
        end else begin
            m_cnt = inc;
        end
        m_prev_vs = dly.vs;
        m_err     = m_err | (rdy != dly.de);
        e.de = dly.de; e.hs = dly.hs; e.vs = dly.vs;
        e.sat_cnt = 16'(m_satcnt); e.err = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pix", pix_o, e.pix);
        check("de", de_o, e.de);
        check("hs", hs_o, e.hs);
        check("vs", vs_o, e.vs);
        check("sat_cnt", sat_cnt_o, e.sat_cnt);
        check("align_err", align_err_o, e.err);
    endtask

    initial begin
        logic vs;
        int   q;
        resetn = 1'b0;
        {rdy_i, de_i, hs_i, vs_i, dz_i} = '0;
        quotient_i = '0; remainder_i = '0; divisor_i = '0;
        apply_reset();

        // Three frames: 10 saturated then clean edge, 10 + saturated edge, restart at 1.
        for (int j = 0; j < int'(LAT) + 30; j++) begin
            vs = (j inside {[10:15], [21:22], [26:60]});
            q  = ((j >= LAT && j <= LAT + 9) || (j >= LAT + 11 && j <= LAT + 21)) ? 300 : 5;
            step(1'b1, (j % 3) == 0, vs, 1'b0, q, 0, 7, 1'b0);
            if (j == LAT + 10) check("frame_cnt_10", sat_cnt_o, 10);
            if (j == LAT + 21) check("frame_cnt_11", sat_cnt_o, 11);
            if (j == LAT + 26) check("frame_cnt_restart", sat_cnt_o, 1);
        end

        step(1'b1, 1'b0, 1'b1, 1'b0, 100, 3, 7, 1'b0);
        check("round_below_half", pix_o, 100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 100, 4, 7, 1'b0);
        check("round_half", pix_o, 100 + RND);
        step(1'b1, 1'b0, 1'b1, 1'b0, 255, 5, 9, 1'b0);
        check("round_into_sat", pix_o, 255);
        step(1'b1, 1'b0, 1'b1, 1'b0, 300, 0, 9, 1'b0);
        check("sat_300", pix_o, 255);
        step(1'b1, 1'b0, 1'b1, 1'b0, 7, 0, 0, 1'b0);
        check("div_zero_no_dz", pix_o, 7 + RND);

        // dz at the chain input must force full scale LAT+1 edges later.
        step(1'b1, 1'b0, 1'b0, 1'b1, 100, 3, 7, 1'b0);
        for (int k = 0; k < int'(LAT) - 1; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 100, 3, 7, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 7, 1'b0);
        check("dz_forces_max", pix_o, 255);
        for (int k = 0; k < int'(LAT); k++) step(1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 7, 1'b0);
        check("dz_frame_count", sat_cnt_o, 2 + RND);

        check("align_clear", align_err_o, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 7, 1'b1);
        check("align_set", align_err_o, 1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 7, 1'b0);
        check("align_sticky", align_err_o, 1);

        apply_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 7, 1'b0);
        for (int k = 0; k <= int'(LAT); k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 7, 1'b0);
            check("de_latency", de_o, (k == int'(LAT) - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
